// File: rtl/hnoc_tree_switch.sv
// Three-port NoC tree node: per-input FIFOs, range routing, round-robin outputs.
// Define HNOC_SW_STATS_EN to build saturating per-output delivery counters.
module hnoc_tree_switch #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 4,
  parameter int FifoDepth  = 4,
  parameter int LeftMin    = 0,
  parameter int LeftMax    = 0,
  parameter int RightMin   = 1,
  parameter int RightMax   = 1,
  parameter int CountWidth = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DataWidth-1:0]  i_left_data,
  input  logic                  i_left_data_valid,
  output logic                  o_left_data_ready,
  output logic [DataWidth-1:0]  o_left_data,
  output logic                  o_left_data_valid,
  input  logic                  i_left_data_ready,
  output logic [CountWidth-1:0] o_left_count,
  input  logic [DataWidth-1:0]  i_right_data,
  input  logic                  i_right_data_valid,
  output logic                  o_right_data_ready,
  output logic [DataWidth-1:0]  o_right_data,
  output logic                  o_right_data_valid,
  input  logic                  i_right_data_ready,
  output logic [CountWidth-1:0] o_right_count,
  input  logic [DataWidth-1:0]  i_parent_data,
  input  logic                  i_parent_data_valid,
  output logic                  o_parent_data_ready,
  output logic [DataWidth-1:0]  o_parent_data,
  output logic                  o_parent_data_valid,
  input  logic                  i_parent_data_ready,
  output logic [CountWidth-1:0] o_parent_count
);

  localparam int PW = $clog2(FifoDepth);
  localparam logic [PW:0] FullCnt = (PW+1)'(FifoDepth);

  logic [DataWidth-1:0] w_in_data [3];
  logic [2:0]           w_in_valid;
  logic [2:0]           w_in_ready;
  logic [2:0]           w_out_ready;
  logic [2:0]           w_push;
  logic [2:0]           w_pop;
  logic [2:0]           w_empty;
  logic [2:0]           w_full;
  logic [DataWidth-1:0] w_head [3];
  logic [1:0]           w_dst [3];
  logic [2:0]           w_req [3];
  logic [2:0]           w_gnt [3];
  logic [2:0]           w_ld_en;
  logic [DataWidth-1:0] w_sel [3];

  logic [DataWidth-1:0] r_mem [3][FifoDepth];
  logic [PW-1:0]        r_wptr [3];
  logic [PW-1:0]        r_rptr [3];
  logic [PW:0]          r_cnt [3];
  logic [DataWidth-1:0] r_odata [3];
  logic [2:0]           r_ovalid;
  logic [1:0]           r_ptr [3];

  assign w_in_data[0] = i_left_data;
  assign w_in_data[1] = i_right_data;
  assign w_in_data[2] = i_parent_data;
  assign w_in_valid   = {i_parent_data_valid, i_right_data_valid,
                         i_left_data_valid};
  assign w_out_ready  = {i_parent_data_ready, i_right_data_ready,
                         i_left_data_ready};

  assign o_left_data_ready   = w_in_ready[0];
  assign o_right_data_ready  = w_in_ready[1];
  assign o_parent_data_ready = w_in_ready[2];
  assign o_left_data         = r_odata[0];
  assign o_right_data        = r_odata[1];
  assign o_parent_data       = r_odata[2];
  assign o_left_data_valid   = r_ovalid[0];
  assign o_right_data_valid  = r_ovalid[1];
  assign o_parent_data_valid = r_ovalid[2];

  function automatic logic [1:0] f_route(input logic [AddrWidth-1:0] a);
    int d;
    d = int'(a);
    if (d >= LeftMin && d <= LeftMax) return 2'd0;
    else if (d >= RightMin && d <= RightMax) return 2'd1;
    else return 2'd2;
  endfunction

  // first requester found scanning from ptr, wrapping left->right->parent
  function automatic logic [2:0] f_pick(input logic [2:0] req,
                                        input logic [1:0] ptr);
    logic [2:0] g;
    logic [2:0] s;
    logic       hit;
    g   = '0;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, ptr} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (!hit && req[s[1:0]]) begin
        g[s[1:0]] = 1'b1;
        hit       = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_empty[i]    = (r_cnt[i] == '0);
      w_full[i]     = (r_cnt[i] == FullCnt);
      w_in_ready[i] = !w_full[i] & !i_reset;
      w_push[i]     = w_in_valid[i] & w_in_ready[i];
      w_head[i]     = r_mem[i][r_rptr[i]];
      w_dst[i]      = f_route(w_head[i][DataWidth-1 -: AddrWidth]);
    end
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++)
        w_req[o][i] = !w_empty[i] && (w_dst[i] == 2'(o));
      w_ld_en[o] = !r_ovalid[o] | w_out_ready[o];
      w_gnt[o]   = f_pick(w_req[o], r_ptr[o]) & {3{w_ld_en[o]}};
      w_sel[o]   = w_gnt[o][0] ? w_head[0] :
                   w_gnt[o][1] ? w_head[1] : w_head[2];
    end
    for (int i = 0; i < 3; i++)
      w_pop[i] = w_gnt[0][i] | w_gnt[1][i] | w_gnt[2][i];
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 3; i++)
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in_data[i];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 3; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_cnt[i]   <= '0;
        r_odata[i] <= '0;
        r_ptr[i]   <= 2'd0;
      end
      r_ovalid <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      for (int o = 0; o < 3; o++) begin
        if (|w_gnt[o]) begin
          r_odata[o]  <= w_sel[o];
          r_ovalid[o] <= 1'b1;
          r_ptr[o]    <= w_gnt[o][0] ? 2'd1 :
                         w_gnt[o][1] ? 2'd2 : 2'd0;
        end else if (w_out_ready[o]) begin
          r_ovalid[o] <= 1'b0;
        end
      end
    end
  end

`ifdef HNOC_SW_STATS_EN
  logic [CountWidth-1:0] r_count [3];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int o = 0; o < 3; o++) r_count[o] <= '0;
    end else begin
      for (int o = 0; o < 3; o++)
        if (r_ovalid[o] && w_out_ready[o] && (r_count[o] != '1))
          r_count[o] <= r_count[o] + 1'b1;
    end
  end

  assign o_left_count   = r_count[0];
  assign o_right_count  = r_count[1];
  assign o_parent_count = r_count[2];
`else
  assign o_left_count   = '0;
  assign o_right_count  = '0;
  assign o_parent_count = '0;
`endif

endmodule

// File: tb/tb_hnoc_tree_switch.sv
// Bench for hnoc_tree_switch: directed cases plus random traffic
// checked against per-(source,destination) ordered scoreboards.
module tb_hnoc_tree_switch;

  localparam int CW   = 4;
  localparam int LMIN = 0;
  localparam int LMAX = 0;
  localparam int RMIN = 1;
  localparam int RMAX = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_v = '0;
  logic [31:0] in_d [3];
  logic [2:0]  ds_rdy = '1;
  logic [2:0]  in_rdy;
  logic [2:0]  out_v;
  logic [31:0] out_d [3];
  logic [CW-1:0] cnt [3];

  int checks = 0;
  int errors = 0;
  int hs [3];
  logic [31:0] sb [9][$];
  logic [2:0]  hold_pend;
  logic [31:0] hold_d [3];

  always #5 clk = ~clk;

  hnoc_tree_switch #(.CountWidth(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_left_data(in_d[0]), .i_left_data_valid(in_v[0]),
    .o_left_data_ready(in_rdy[0]), .o_left_data(out_d[0]),
    .o_left_data_valid(out_v[0]), .i_left_data_ready(ds_rdy[0]),
    .o_left_count(cnt[0]),
    .i_right_data(in_d[1]), .i_right_data_valid(in_v[1]),
    .o_right_data_ready(in_rdy[1]), .o_right_data(out_d[1]),
    .o_right_data_valid(out_v[1]), .i_right_data_ready(ds_rdy[1]),
    .o_right_count(cnt[1]),
    .i_parent_data(in_d[2]), .i_parent_data_valid(in_v[2]),
    .o_parent_data_ready(in_rdy[2]), .o_parent_data(out_d[2]),
    .o_parent_data_valid(out_v[2]), .i_parent_data_ready(ds_rdy[2]),
    .o_parent_count(cnt[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_route(input logic [3:0] dest);
    int d;
    d = int'(dest);
    if (d >= LMIN && d <= LMAX) return 0;
    if (d >= RMIN && d <= RMAX) return 1;
    return 2;
  endfunction

  function automatic int exp_count(input int n);
`ifdef HNOC_SW_STATS_EN
    return (n > (2**CW - 1)) ? (2**CW - 1) : n;
`else
    return 0;
`endif
  endfunction

  // reference model: ordered queues per (input, output) plus handshake counts
  initial begin
    hold_pend = '0;
    for (int o = 0; o < 3; o++) hs[o] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int q = 0; q < 9; q++) sb[q].delete();
        for (int o = 0; o < 3; o++) begin
          hs[o] = 0;
          chk("rst_valid", 32'(out_v[o]), 32'd0);
          chk("rst_ready", 32'(in_rdy[o]), 32'd0);
          chk("rst_count", 32'(cnt[o]), 32'd0);
        end
        hold_pend = '0;
      end else begin
        for (int o = 0; o < 3; o++) begin
          chk("count", 32'(cnt[o]), 32'(exp_count(hs[o])));
          if (hold_pend[o]) begin
            chk("hold_valid", 32'(out_v[o]), 32'd1);
            chk("hold_data", out_d[o], hold_d[o]);
          end
          if (out_v[o] && ds_rdy[o]) begin
            logic found;
            found = 1'b0;
            for (int s = 0; s < 3; s++) begin
              if (!found && sb[s*3+o].size() > 0 &&
                  sb[s*3+o][0] == out_d[o]) begin
                void'(sb[s*3+o].pop_front());
                found = 1'b1;
              end
            end
            chk("sb_order_route", 32'(found), 32'd1);
            hs[o]++;
          end
          hold_pend[o] = out_v[o] & !ds_rdy[o];
          hold_d[o]    = out_d[o];
        end
        for (int i = 0; i < 3; i++)
          if (in_v[i] && in_rdy[i])
            sb[i*3 + ref_route(in_d[i][31:28])].push_back(in_d[i]);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_v = '0;
    ds_rdy = '1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int p,
                          input logic [31:0] exp);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      if (out_v[p]) begin
        ok = 1'b1;
        chk(nm, out_d[p], exp);
      end
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_exp [6];
    logic [2:0]  acc;
    int          n;
    int          seq;
    logic        a;
    for (int i = 0; i < 3; i++) in_d[i] = '0;
    seq = 0;
    do_reset();

    // single route, one-cycle latency
    in_v[0] = 1'b1;
    in_d[0] = 32'h1000_00AA;
    @(negedge clk);
    chk("sr_accept_ready", 32'(in_rdy[0]), 32'd1);
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    @(negedge clk);
    chk("sr_lat_early", 32'(out_v[1]), 32'd0);
    @(negedge clk);
    chk("sr_valid", 32'(out_v[1]), 32'd1);
    chk("sr_data", out_d[1], 32'h1000_00AA);
    chk("sr_left_idle", 32'(out_v[0]), 32'd0);
    chk("sr_parent_idle", 32'(out_v[2]), 32'd0);
    @(negedge clk);
    chk("sr_gone", 32'(out_v[1]), 32'd0);

    // default-to-parent and U-turn
    @(posedge clk); #1;
    in_v[1] = 1'b1;
    in_d[1] = 32'h5000_0001;
    @(posedge clk); #1;
    in_v[1] = 1'b0;
    wait_out("to_parent", 2, 32'h5000_0001);
    @(posedge clk); #1;
    in_v[0] = 1'b1;
    in_d[0] = 32'h0000_0002;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    wait_out("uturn_left", 0, 32'h0000_0002);

    // round-robin contention on the left output
    do_reset();
    in_v = 3'b111;
    in_d[0] = 32'h0000_000A;
    in_d[1] = 32'h0000_000B;
    in_d[2] = 32'h0000_000C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_v = '0;
    rr_exp = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB, 32'hC};
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      else #4;
      chk("rr_valid", 32'(out_v[0]), 32'd1);
      chk("rr_data", out_d[0], rr_exp[j]);
    end

    // backpressure fills output register plus FIFO
    do_reset();
    ds_rdy[1] = 1'b0;
    n = 0;
    in_v[0] = 1'b1;
    in_d[0] = {4'h1, 28'(n)};
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!in_rdy[0]) break;
      @(posedge clk); #1;
      n++;
      in_d[0] = {4'h1, 28'(n)};
    end
    in_v[0] = 1'b0;
    chk("bp_accepted", 32'(n), 32'd5);
    chk("bp_ready_low", 32'(in_rdy[0]), 32'd0);
    chk("bp_out_valid", 32'(out_v[1]), 32'd1);
    chk("bp_out_first", out_d[1], {4'h1, 28'd0});
    @(posedge clk); #1;
    ds_rdy[1] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(out_v[1]), 32'd1);
      chk("bp_drain_data", out_d[1], {4'h1, 28'(j)});
    end
    @(negedge clk);
    chk("bp_drain_done", 32'(out_v[1]), 32'd0);

    // statistics saturation on parent
    do_reset();
    n = 0;
    in_v[1] = 1'b1;
    in_d[1] = {4'h5, 28'(n)};
    for (int t = 0; t < 60 && n < 20; t++) begin
      @(negedge clk);
      a = in_rdy[1];
      @(posedge clk); #1;
      if (a) begin
        n++;
        in_d[1] = {4'h5, 28'(n)};
      end
    end
    in_v[1] = 1'b0;
    chk("sat_sent", 32'(n), 32'd20);
    repeat (8) @(negedge clk);
`ifdef HNOC_SW_STATS_EN
    chk("sat_count", 32'(cnt[2]), 32'd15);
`else
    chk("sat_count", 32'(cnt[2]), 32'd0);
`endif

    // reset mid-stream discards everything
    @(posedge clk); #1;
    ds_rdy = '0;
    in_v[0] = 1'b1;
    in_d[0] = 32'h5000_0100;
    @(posedge clk); #1;
    in_d[0] = 32'h5000_0101;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    chk("mid_pre_valid", 32'(out_v[2]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_valids", 32'(out_v), 32'd0);
    chk("mid_ready", 32'(in_rdy), 32'd0);
    chk("mid_pcount", 32'(cnt[2]), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    ds_rdy = '1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_partial", 32'(out_v), 32'd0);
    end
    @(posedge clk); #1;
    in_v[0] = 1'b1;
    in_d[0] = 32'h5000_0ABC;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    wait_out("mid_fresh", 2, 32'h5000_0ABC);

    // randomized traffic against the scoreboard
    do_reset();
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_v & in_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!in_v[i] || acc[i]) begin
          in_v[i] = ($urandom_range(0, 3) != 0);
          in_d[i] = {4'($urandom_range(0, 15)), 28'(seq)};
          seq++;
        end
        ds_rdy[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    in_v = '0;
    ds_rdy = '1;
    repeat (40) @(negedge clk);
    for (int q = 0; q < 9; q++)
      chk("drain_empty", 32'(sb[q].size()), 32'd0);
    chk("drain_idle", 32'(out_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hnoc_tree_switch.md
# hnoc_tree_switch

Parametrised single-clock three-port routing node for the hierarchical NoC: left child, right child and parent. Each input is buffered in a FIFO of configurable depth. Each flit is routed by a destination field, compared against per-child address ranges that are set by parameters. Each output is arbitrated round-robin. Instances are composed into binary trees for PE counts beyond four. All ports use valid/ready handshakes.

## Interface
- DataWidth, 32, flit width in bits.
- AddrWidth, 4, width of destination field `data[DataWidth-1 -: AddrWidth]`.
- FifoDepth, 4, entries per input FIFO; power of two, ≥2.
- LeftMin / LeftMax, 0 / 0, inclusive destination range served by the left port.
- RightMin / RightMax, 1 / 1, inclusive destination range served by the right port.
- CountWidth, 16, width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; asynchronous, active-high.
- For each port P in {left, right, parent}:
  - i_P_data  in  DataWidth  inbound flit.
  - i_P_data_valid  in  1  inbound valid.
  - o_P_data_ready  out  1  inbound ready.
  - o_P_data  out  DataWidth  outbound flit.
  - o_P_data_valid  out  1  outbound valid.
  - i_P_data_ready  in  1  outbound ready.
  - o_P_count  out  CountWidth  flits delivered on outbound P.

## Operation
- **Input acceptance:** a flit is accepted on the rising edge where valid & ready.
- **Input ready:** o_P_data_ready = !fifo_full & !i_reset. There is no bypass: a full FIFO does not accept a flit, even in a cycle where it is also popped.
- **Routing of each FIFO head, by dest:**
  - dest in [LeftMin, LeftMax] → left.
  - else dest in [RightMin, RightMax] → right.
  - else → parent.
  - If the ranges overlap, left wins.
  - U-turns are legal: a flit is routed back out of its arrival port if dest selects that port.
- **Output register:** each output has a one-entry register, which can load when it is empty or being drained (o_valid & i_ready).
- **Arbitration:** per output, round-robin among FIFO heads that request it.
  - Priority order starts at the pointer and runs left → right → parent, wrapping.
  - After a grant, the pointer moves to the input after the granted one. With no grant, the pointer holds.
- **Pop:** a granted head is popped from its FIFO in the same cycle.
  - One head requests exactly one output, so no input is granted twice.
  - Heads that are not granted stay in place; no reordering within an input.
- **Output hold:** o_P_data and o_P_data_valid hold stable while o_P_data_valid & !i_P_data_ready.
- **Ordering:** flits from the same input to the same output are delivered in arrival order.

## Timing
- **Reset values:**
  - o_*_data_valid = 0; o_*_data = 0; o_*_data_ready = 0 while i_reset is high.
  - FIFOs empty; arbitration pointers = left; counters = 0.
- **Latency:**
  - Flit accepted at edge k into an empty FIFO, with a free output and no contention → o_valid is high from edge k+1.
  - Minimum latency is 1 cycle.
- **Throughput:**
  - Each output delivers 1 flit/cycle while the downstream ready is held high.
  - Each input sustains 1 flit/cycle while its head keeps winning.
- **Contention:** with all three heads requesting the same output and the downstream always ready, grants rotate left, right, parent, left… one per cycle.
- **FIFO boundaries:**
  - Full: FifoDepth flits are stored and ready drops in the same cycle as the write that fills the FIFO.
  - Wrap-around: read/write pointers are log2(FifoDepth) bits and wrap naturally; a separate count distinguishes full from empty.
- **Reset mid-operation:** all buffered and in-flight flits are discarded immediately (asynchronous). There is no partial delivery after reset is released.

## Configuration
- HNOC_SW_STATS_EN defined:
  - o_P_count increments on each outbound handshake (o_valid & i_ready) on port P.
  - The counter saturates at 2^CountWidth−1; it does not wrap.
  - Cleared by reset.
- HNOC_SW_STATS_EN undefined:
  - Counter logic is not built.
  - o_*_count are tied to 0.

## Test plan
- **Single route:** defaults; inject 0x1000_00AA on left (dest 1), downstream always ready → o_right_data = 0x1000_00AA, valid one cycle after acceptance; other outputs stay idle.
- **Default to parent and U-turn:**
  - Inject dest 5 on right → flit exits parent.
  - Inject dest 0 on left → flit exits left (U-turn).
- **Round-robin:** all three inputs hold dest-0 flits 0xA, 0xB, 0xC in parallel for 6 cycles → o_left_data sequence is left, right, parent, left, right, parent; no starvation.
- **Backpressure/full:**
  - Hold i_right_data_ready = 0 and stream dest-1 flits from left → 1 flit sits in the output register, FifoDepth flits fill the FIFO, then o_left_data_ready falls.
  - Release ready → all FifoDepth+1 flits arrive in order, with no loss or duplication.
- **Reset mid-stream:** assert i_reset with flits buffered → all valids go low immediately and counters read 0; after release, a fresh flit routes normally.
- **Statistics saturation:** CountWidth=4 with HNOC_SW_STATS_EN defined; deliver 20 flits to parent → o_parent_count = 15. With the macro undefined → o_parent_count = 0.
